// File: rtl/btn_deb_pkg.sv
// Package: btn_deb_pkg
// Shared definitions for the multi-channel button debouncer.
//  - btn_state_t : per-channel confirm FSM state encoding
//  - DEF_*       : default parameter values (12 MHz board, 1 ms sample tick)
// Optional feature macro: BTN_DEB_LONG_PRESS_EN (see btn_deb_ch / btn_deb_multi).
package btn_deb_pkg;

    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        PRESS_CHK   = 2'd1,
        PRESSED     = 2'd2,
        RELEASE_CHK = 2'd3
    } btn_state_t;

    localparam int DEF_BTN_WIDTH    = 8;
    localparam int DEF_ACTIVE_LOW   = 1;
    localparam int DEF_TICK_DIV     = 12000;
    localparam int DEF_STABLE_TICKS = 20;
    localparam int DEF_LONG_TICKS   = 1000;

endpackage

// File: rtl/btn_deb_ch.sv
// Module: btn_deb_ch
// One debouncer channel: 2-FF synchroniser, confirm FSM with sample counter
// and, when BTN_DEB_LONG_PRESS_EN is defined, a long-press hold counter.
// All FSM/counter updates happen only on cycles where tick is high; the
// outputs are registered, so they move the clk after the confirming tick.
//
// Ports
//  clk           in   system clock
//  rst_n         in   asynchronous reset, active low
//  tick          in   shared 1-clk sample strobe
//  pin           in   raw asynchronous button pin
//  level         out  debounced level, 1 = pressed
//  press_pulse   out  1-clk pulse on confirmed press
//  release_pulse out  1-clk pulse on confirmed release
//  long_pulse    out  1-clk pulse at long-press threshold (0 without macro)
//
// State        | meaning
// RELEASED     | stable released, waiting for a pressed sample
// PRESS_CHK    | counting consecutive pressed samples
// PRESSED      | stable pressed, waiting for a released sample
// RELEASE_CHK  | counting consecutive released samples
import btn_deb_pkg::*;

module btn_deb_ch #(
    parameter int ACTIVE_LOW   = DEF_ACTIVE_LOW,
    parameter int STABLE_TICKS = DEF_STABLE_TICKS,
    parameter int LONG_TICKS   = DEF_LONG_TICKS
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic pin,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    localparam int            CW       = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);
    localparam logic          IDLE_PIN = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    logic sync1;
    logic sync2;
    logic smp;

    // Sync flops idle at the released pin level so reset release never
    // looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= IDLE_PIN;
            sync2 <= IDLE_PIN;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
        end
    end

    assign smp = (ACTIVE_LOW != 0) ? ~sync2 : sync2;

    btn_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RELEASED;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (tick) begin
            case (state_q)
                RELEASED: begin
                    if (smp) begin
                        state_d = PRESS_CHK;
                        cnt_d   = CW'(1);
                    end
                end
                PRESS_CHK: begin
                    if (!smp) begin
                        state_d = RELEASED;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                        level_d = 1'b1;
                        press_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!smp) begin
                        state_d = RELEASE_CHK;
                        cnt_d   = CW'(1);
                    end
                end
                RELEASE_CHK: begin
                    if (smp) begin
                        // Bounce back to pressed: no release was confirmed.
                        state_d = PRESSED;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d   = RELEASED;
                        cnt_d     = '0;
                        level_d   = 1'b0;
                        release_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                    level_d = 1'b0;
                end
            endcase
        end
    end

    assign level         = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

`ifdef BTN_DEB_LONG_PRESS_EN
    localparam int            LW       = (LONG_TICKS > 0) ? $clog2(LONG_TICKS + 1) : 1;
    localparam logic [LW-1:0] LCNT_MAX = LW'(LONG_TICKS);

    logic [LW-1:0] lcnt_q, lcnt_d;
    logic          long_q, long_d;

    // lcnt only advances in the stable PRESSED state, freezes through a
    // release check and saturates at the threshold so each hold fires once.
    always_comb begin
        lcnt_d = lcnt_q;
        long_d = 1'b0;
        if (tick && (state_q == PRESSED) && (lcnt_q != LCNT_MAX)) begin
            lcnt_d = lcnt_q + 1'b1;
            long_d = (lcnt_d == LCNT_MAX);
        end
        if (state_d == RELEASED) begin
            lcnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lcnt_q <= '0;
            long_q <= 1'b0;
        end else begin
            lcnt_q <= lcnt_d;
            long_q <= long_d;
        end
    end

    assign long_pulse = long_q;
`else
    assign long_pulse = 1'b0;
`endif

endmodule

// File: rtl/btn_deb_multi.sv
// Module: btn_deb_multi
// Multi-channel button debouncer. Holds the shared sample-tick prescaler and
// one btn_deb_ch per channel.
// Optional feature: define BTN_DEB_LONG_PRESS_EN to enable btn_long pulses
// after LONG_TICKS held ticks; otherwise btn_long is constant 0.
//
// Ports
//  clk          in   system clock (12 MHz)
//  rst_n        in   asynchronous reset, active low
//  btn_in       in   raw pins, asynchronous
//  btn_level    out  debounced level per channel, 1 = pressed
//  btn_press    out  1-clk pulse on confirmed press
//  btn_release  out  1-clk pulse on confirmed release
//  btn_long     out  1-clk pulse at long-press threshold
import btn_deb_pkg::*;

module btn_deb_multi #(
    parameter int BTN_WIDTH    = DEF_BTN_WIDTH,
    parameter int ACTIVE_LOW   = DEF_ACTIVE_LOW,
    parameter int TICK_DIV     = DEF_TICK_DIV,
    parameter int STABLE_TICKS = DEF_STABLE_TICKS,
    parameter int LONG_TICKS   = DEF_LONG_TICKS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BTN_WIDTH-1:0] btn_in,
    output logic [BTN_WIDTH-1:0] btn_level,
    output logic [BTN_WIDTH-1:0] btn_press,
    output logic [BTN_WIDTH-1:0] btn_release,
    output logic [BTN_WIDTH-1:0] btn_long
);

    localparam int            TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    logic [TW-1:0] tick_cnt;
    logic          tick;

    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    for (genvar g = 0; g < BTN_WIDTH; g++) begin : g_ch
        btn_deb_ch #(
            .ACTIVE_LOW   (ACTIVE_LOW),
            .STABLE_TICKS (STABLE_TICKS),
            .LONG_TICKS   (LONG_TICKS)
        ) u_ch (
            .clk           (clk),
            .rst_n         (rst_n),
            .tick          (tick),
            .pin           (btn_in[g]),
            .level         (btn_level[g]),
            .press_pulse   (btn_press[g]),
            .release_pulse (btn_release[g]),
            .long_pulse    (btn_long[g])
        );
    end

endmodule
